timer_irq_src: RTL and testbench
================================

Name: timer_irq_src

Overview:
- Memory-mapped countdown timer that drives one `hwirq` line of the coprocessor-0 interrupt logic, the interrupt source directly upstream of it.
- Software programs a preset value and a mode over the data bus.
- The block counts down and raises `irq` on expiry, either one-shot (level, held) or auto-reload (periodic 1-cycle pulse).

Parameters:
- PRESCALE, 1, number of clk cycles per count decrement. Used only when TIMER_PRESCALE_EN is defined; must be ≥1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  2  word select (bus addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- write_enable  in  1  bus write strobe, sampled on clk edge
- write_data  in  32  bus write data
- read_data  out  32  combinational read of register selected by addr
- irq  out  1  interrupt request to cp0 hwirq bit

Behaviour:
- CTRL register: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), bit3 IM (irq mask, 1=allow). Bits 31:4 read 0, writes ignored.
- PRESET: 32-bit, read/write.
- COUNT: 32-bit, read-only; writes ignored. Reserved address reads 0, writes ignored.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0. Hence irq=0, read_data follows addr.
- irq = pending & IM (combinational from registers).
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - if !EN → IDLE, COUNT holds;
    - else if COUNT>1 → COUNT−1;
    - else (COUNT is 1 or 0) → COUNT ← 0, go to INT.
  - INT, one-shot: pending ← 1; EN ← 0; → IDLE.
  - INT, auto-reload: pending ← 1 for exactly this edge (cleared next cycle); → LOAD.
- Latency, one-shot: irq rises on the (max(PRESET,1)+3)th rising edge after the edge that commits the EN write. Example: PRESET=5 gives the 8th edge.
- Auto-reload period is max(PRESET,1)+2 cycles between pulses.
- One-shot pending stays set until any bus write to CTRL or PRESET, which clears it at that edge.
- A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
- Clearing EN via a CTRL write during CNT or LOAD: FSM reaches IDLE within one cycle; no irq is produced.
- A CTRL write in the same cycle as INT-state one-shot EN clear: the bus write wins for EN. Pending still sets, then is cleared by the write rule only on a later write.
- A write in the same cycle as auto-reload pending set: pending set wins for that one cycle.
- IM=0 masks irq but pending still tracks as specified. Setting IM later exposes a held one-shot pending.
- COUNT never wraps below 0.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined: an internal prescale counter advances in CNT. COUNT decrements only on the cycle the prescaler reaches PRESCALE−1, and the prescaler then returns to 0. The prescaler resets to 0 on rst, in LOAD and in IDLE. Expiry check (COUNT≤1) also occurs only on a prescale tick.
- Undefined: decrement every cycle in CNT; PRESCALE ignored; no prescaler register exists.

Test Plan:
- Reset mid-count: PRESET=100, CTRL=0x9, assert rst after 10 cycles → COUNT, CTRL, PRESET read 0; irq=0 immediately (async).
- One-shot: write PRESET=5, then CTRL=0x9 → irq rises on the 8th edge after the CTRL write and stays high. CTRL reads 0x8 (EN cleared). Writing CTRL=0x8 drops irq at that edge.
- Auto-reload: PRESET=3, CTRL=0xB → irq pulses 1 cycle wide every 5 cycles. COUNT reads 3,2,1,0 pattern between pulses. Pulses stop after CTRL=0x0.
- Mask: PRESET=2, CTRL=0x1 (IM=0) → irq stays 0 after expiry. Writing IM via CTRL=0x8 clears pending, so irq stays 0. Repeating with CTRL=0x9 → irq rises.
- Cancel and boundary: PRESET=0, CTRL=0x9 → irq on the 4th edge. Separately, PRESET=50, enable, write CTRL=0x8 at COUNT=20 → COUNT freezes at ≤20 and no irq ever. A PRESET write mid-count leaves COUNT unaffected.
- Prescale (macro defined, PRESCALE=4): PRESET=2, CTRL=0x9 → COUNT changes every 4 cycles; irq on edge 2+4·2+1=11 after the CTRL write.

Source files
------------

// File: rtl/timer_irq_src.sv
// ============================================================================
// Module      : timer_irq_src
// Description : Memory-mapped countdown timer feeding one cp0 hwirq line.
//               Registers: CTRL (EN, MODE, IM), PRESET (r/w), COUNT (r/o).
//               One-shot expiry holds a level irq until the next CTRL/PRESET
//               write; auto-reload expiry emits a one-cycle pulse per period.
//               Optional macro TIMER_PRESCALE_EN inserts a PRESCALE-cycle
//               prescaler in front of the COUNT decrement.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module timer_irq_src #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq
);

  // Register map word indices
  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_PRESET = 2'd1;
  localparam logic [1:0] c_ADDR_COUNT  = 2'd2;

  // FSM state encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_CNT  = 2'd2;
  localparam logic [1:0] c_ST_INT  = 2'd3;

  // MODE value selecting auto-reload; every other encoding behaves one-shot
  localparam logic [1:0] c_MODE_AUTO = 2'b01;

  logic [1:0]  r_state;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  logic        r_pulse_clr;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_oneshot;
  logic        w_tick;

  assign w_wr_ctrl   = write_enable && (addr == c_ADDR_CTRL);
  assign w_wr_preset = write_enable && (addr == c_ADDR_PRESET);
  assign w_oneshot   = (r_mode != c_MODE_AUTO);

  // A PRESCALE of zero has no meaning; nothing elaborates for legal values.
  if (PRESCALE < 1) begin : g_prescale_invalid
  end

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

  logic [c_PS_W-1:0] r_ps;

  assign w_tick = (r_ps == c_PS_LAST);

  // Prescaler runs only while actively counting; it restarts from 0 otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps <= '0;
    end else if (r_state == c_ST_CNT && r_en) begin
      r_ps <= w_tick ? '0 : r_ps + 1'b1;
    end else begin
      r_ps <= '0;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Timer FSM and COUNT register; COUNT saturates at 0 on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (r_en) r_state <= c_ST_LOAD;
        end
        c_ST_LOAD: begin
          r_count <= r_preset;
          r_state <= c_ST_CNT;
        end
        c_ST_CNT: begin
          if (!r_en) begin
            r_state <= c_ST_IDLE;
          end else if (w_tick) begin
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count <= '0;
              r_state <= c_ST_INT;
            end
          end
        end
        c_ST_INT: begin
          r_state <= w_oneshot ? c_ST_IDLE : c_ST_LOAD;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // CTRL fields; a bus write beats the one-shot self-clear of EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_mode <= 2'b00;
      r_im   <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= write_data[0];
      r_mode <= write_data[2:1];
      r_im   <= write_data[3];
    end else if (r_state == c_ST_INT && w_oneshot) begin
      r_en   <= 1'b0;
    end
  end

  // PRESET only changes by bus write; COUNT picks it up at the next LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= write_data;
    end
  end

  // Pending: set on expiry (wins over writes), cleared by CTRL/PRESET writes
  // or, for auto-reload, automatically one cycle after being set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_pulse_clr <= 1'b0;
    end else if (r_state == c_ST_INT) begin
      r_pending   <= 1'b1;
      r_pulse_clr <= !w_oneshot;
    end else begin
      r_pulse_clr <= 1'b0;
      if (w_wr_ctrl || w_wr_preset || r_pulse_clr) r_pending <= 1'b0;
    end
  end

  // Combinational register read-back; reserved word reads as zero
  always_comb begin
    read_data = '0;
    case (addr)
      c_ADDR_CTRL:   read_data = {28'd0, r_im, r_mode, r_en};
      c_ADDR_PRESET: read_data = r_preset;
      c_ADDR_COUNT:  read_data = r_count;
      default:       read_data = '0;
    endcase
  end

  assign irq = r_pending & r_im;

endmodule

`default_nettype wire

// File: tb/tb_timer_irq_src.sv
// ============================================================================
// Module      : tb_timer_irq_src
// Description : Randomized scoreboard bench for timer_irq_src. Expected irq
//               and register values come from closed-form timing rules
//               (latency, period, countdown value per edge).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_timer_irq_src;

`ifdef TIMER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        irq;

  timer_irq_src #(.PRESCALE(PS)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_irq;
    bit          e_irq;
    bit          chk_rd;
    logic [31:0] e_rd;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check32(input string tag, input logic [31:0] act,
                                  input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endfunction

  // Reference rules
  function automatic int maxp(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  // COUNT after edge j (j>=2) of a one-shot run started by the CTRL write
  function automatic int cnt_os(input int p, input int j);
    int v;
    v = p - (j - 2) / PS;
    return (v < 0) ? 0 : v;
  endfunction

  // COUNT after edge j (j>=2) of an auto-reload run of period t
  function automatic int cnt_ar(input int p, input int j, input int t);
    int v;
    v = p - ((j - 2) % t) / PS;
    return (v < 0) ? 0 : v;
  endfunction

  // Monitor: every negedge, pop the expectation for the state after the last posedge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.chk_irq) check32({mon_e.tag, "_irq"}, {31'd0, irq}, {31'd0, mon_e.e_irq});
      if (mon_e.chk_rd)  check32({mon_e.tag, "_rd"}, read_data, mon_e.e_rd);
    end
  end

  // One bus cycle: drive just after posedge, queue what the monitor must see
  task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] wd,
                     input bit ci, input bit ei, input bit cr,
                     input logic [31:0] er, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    write_enable = we;
    addr         = a;
    write_data   = wd;
    e.chk_irq = ci;
    e.e_irq   = ei;
    e.chk_rd  = cr;
    e.e_rd    = er;
    e.tag     = tag;
    sbq.push_back(e);
  endtask

  task automatic do_oneshot(input int p, input logic [1:0] mode, input bit im,
                            input bit clear);
    int n;
    n = maxp(p) * PS + 3;
    cyc(1, 2'd1, p, 0, 0, 0, 0, "os_wp");
    cyc(1, 2'd0, {28'd0, im, mode, 1'b1}, 1, 0, 0, 0, "os_wc");
    for (int j = 0; j <= n + 3; j++)
      cyc(0, 2'd2, 0, 1, im && (j >= n), j >= 2, cnt_os(p, j), "os_run");
    cyc(0, 2'd0, 0, 1, im, 1, {28'd0, im, mode, 1'b0}, "os_ctrl");
    cyc(0, 2'd1, 0, 1, im, 1, p, "os_preset");
    if (clear) begin
      cyc(1, 2'd0, 32'h8, 1, im, 0, 0, "os_wclr");
      cyc(0, 2'd0, 0, 1, 0, 1, 32'h8, "os_cleared");
    end
  endtask

  task automatic do_auto(input int p, input int s);
    int t, n;
    bit we, ei;
    t = maxp(p) * PS + 2;
    n = t + 1;
    cyc(1, 2'd1, p, 0, 0, 0, 0, "ar_wp");
    cyc(1, 2'd0, 32'hB, 1, 0, 0, 0, "ar_wc");
    for (int j = 0; j <= s + t + 4; j++) begin
      we = (j == s - 1);
      ei = (j >= n) && (((j - n) % t) == 0) && (j <= s);
      cyc(we, we ? 2'd0 : 2'd2, 0, 1, ei, !we && j >= 2 && j <= s,
          cnt_ar(p, j, t), "ar_run");
    end
    cyc(0, 2'd0, 0, 1, 0, 1, 0, "ar_ctrl");
  endtask

  // Masked one-shot whose expiry edge coincides with a CTRL write setting IM
  task automatic do_expose(input int p);
    int n;
    bit we;
    n = maxp(p) * PS + 3;
    cyc(1, 2'd1, p, 0, 0, 0, 0, "ex_wp");
    cyc(1, 2'd0, 32'h1, 1, 0, 0, 0, "ex_wc");
    for (int j = 0; j <= n + 3; j++) begin
      we = (j == n - 1);
      cyc(we, 2'd0, 32'h8, 1, j >= n, !we, (j < n) ? 32'h1 : 32'h8, "ex_run");
    end
    cyc(1, 2'd0, 32'h8, 1, 1, 0, 0, "ex_wclr");
    cyc(0, 2'd0, 0, 1, 0, 1, 32'h8, "ex_cleared");
  endtask

  task automatic do_cancel();
    int jc;
    bit wp, wc;
    jc = 2 + 30 * PS;
    cyc(1, 2'd1, 50, 0, 0, 0, 0, "cn_wp");
    cyc(1, 2'd0, 32'h9, 1, 0, 0, 0, "cn_wc");
    for (int j = 0; j <= jc + 30; j++) begin
      wp = (j == 9);
      wc = (j == jc - 1);
      cyc(wp || wc, wc ? 2'd0 : (wp ? 2'd1 : 2'd2), wc ? 32'h8 : 32'h7,
          1, 0, !(wp || wc) && j >= 2,
          (j <= jc) ? cnt_os(50, j) : cnt_os(50, jc), "cn_run");
    end
    cyc(0, 2'd1, 0, 1, 0, 1, 32'h7, "cn_preset");
    cyc(0, 2'd0, 0, 1, 0, 1, 32'h8, "cn_ctrl");
  endtask

  task automatic check_zero_regs(input string tag);
    write_enable = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check32(tag, read_data, 32'd0);
    end
    check32({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  logic [1:0] modes [3] = '{2'b00, 2'b10, 2'b11};

  initial begin
    int p, t, s;
    #3;
    check_zero_regs("reset_init");
    @(negedge clk);
    rst = 1'b0;

    do_oneshot(5, 2'b00, 1, 1);
    do_oneshot(0, 2'b00, 1, 1);
    for (int k = 0; k < 4; k++)
      do_oneshot($urandom_range(0, 12), modes[$urandom_range(0, 2)], 1,
                 1'($urandom_range(0, 1)));

    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 3 : $urandom_range(0, 6);
      t = maxp(p) * PS + 2;
      s = $urandom_range(2 * t + 3, 4 * t);
      // keep the disabling write clear of an expiry edge
      while (((s + 1 - (t + 1)) % t) == 0 || ((s - (t + 1)) % t) == 0) s++;
      do_auto(p, s);
    end

    do_oneshot(2, 2'b00, 0, 1);
    do_oneshot(2, 2'b00, 1, 1);
    do_expose($urandom_range(1, 6));
    do_cancel();

    // Asynchronous reset while a one-shot irq is held
    do_oneshot(3, 2'b00, 1, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check32("rst_async_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-count
    cyc(1, 2'd1, 100, 0, 0, 0, 0, "rm_wp");
    cyc(1, 2'd0, 32'h9, 0, 0, 0, 0, "rm_wc");
    for (int j = 0; j < 10; j++) cyc(0, 2'd2, 0, 0, 0, 0, 0, "rm_run");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero_regs("rst_midcount");
    @(negedge clk);
    rst = 1'b0;

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
